add_seq_ctrl: RTL and testbench

- Sequencer that performs a WORDS×5-bit add or subtract by iterating one 5-bit ripple-add slice.
- Processes one 5-bit word per clock, least-significant word first, holding the inter-word carry in a register.
- Sits between a requester using a start/busy/done handshake and the shared 5-bit adder datapath.
- Reuses the existing 5-bit full-adder style datapath so that wide adds cost no extra adder area.

---
 rtl/add_seq_ctrl_pkg.sv | 17 +
 rtl/add5_slice.sv | 34 +++
 rtl/add_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_add_seq_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the word-serial add/subtract sequencer.
package add_seq_ctrl_pkg;

    localparam int WBITS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the word index counter; a single-word build still needs one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/add5_slice.sv
// One 5-bit ripple-carry adder slice, reused for every word of a wide operation.
module add5_slice
    import add_seq_ctrl_pkg::*;
(
    input  logic [WBITS-1:0] a,
    input  logic [WBITS-1:0] b,
    input  logic             ci,
    output logic [WBITS-1:0] s,
    output logic             co
);

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    logic [WBITS:0] carry;

    // Ripple the carry through one full adder per bit.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int i = 0; i < WBITS; i++) begin
            s[i]       = fa_sum(a[i], b[i], carry[i]);
            carry[i+1] = fa_carry(a[i], b[i], carry[i]);
        end
        co = carry[WBITS];
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Word-serial add/subtract controller: walks a WORDS x 5-bit operation through a
// single shared 5-bit slice, least-significant word first.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = WBITS * WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic         clr,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int            IW   = idx_width(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t         state;
    state_t         state_d;
    logic           load;
    logic           step;
    logic [IW-1:0]  idx;
    logic           carry_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;

    logic [WBITS-1:0] a_words [WORDS];
    logic [WBITS-1:0] b_words [WORDS];
    logic [WBITS-1:0] slice_s;
    logic             slice_co;

    for (genvar g = 0; g < WORDS; g++) begin : g_split
        assign a_words[g] = a_q[g*WBITS +: WBITS];
        assign b_words[g] = b_q[g*WBITS +: WBITS];
    end

    add5_slice u_slice (
        .a  (a_words[idx]),
        .b  (b_words[idx]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Next-state decode; clr overrides everything, including a same-cycle start.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            load    = 1'b0;
            step    = 1'b0;
        end
    end

    // State, operand capture and per-word result/carry update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state <= state_d;
            if (load) begin
                a_q     <= a;
                b_q     <= sub ? ~b : b;
                carry_q <= sub ? 1'b1 : cin;
                idx     <= '0;
            end else if (step) begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx == IW'(w)) begin
                        sum[w*WBITS +: WBITS] <= slice_s;
                    end
                end
                carry_q <= slice_co;
                if (idx == LAST) begin
                    cout <= slice_co;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl: a 4-word instance and a 1-word instance,
// results checked against a queue of expected {cout, sum} values.
module tb_add_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;

    logic        start4, sub4, cin4;
    logic [19:0] a4, b4;
    logic        busy4, done4, cout4;
    logic [19:0] sum4;

    logic        start1, sub1, cin1;
    logic [4:0]  a1, b1;
    logic        busy1, done1, cout1;
    logic [4:0]  sum1;

    int vectors     = 0;
    int miscompares = 0;

    logic [20:0] sb4 [$];
    logic [5:0]  sb1 [$];

    add_seq_ctrl #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .clr(clr),
        .a(a4), .b(b4), .cin(cin4), .busy(busy4), .done(done4),
        .sum(sum4), .cout(cout4)
    );

    add_seq_ctrl #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .clr(clr),
        .a(a1), .b(b1), .cin(cin1), .busy(busy1), .done(done1),
        .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] model4(input logic [19:0] x, input logic [19:0] y,
                                           input logic ci, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + 21'd1;
        return {1'b0, x} + {1'b0, y} + {20'd0, ci};
    endfunction

    // Drive one start pulse on the 4-word instance and queue its expected result.
    task automatic applyStimulus(input logic [19:0] x, input logic [19:0] y,
                                 input logic ci, input logic s, input logic [20:0] exp);
        start4 = 1'b1;
        a4 = x; b4 = y; cin4 = ci; sub4 = s;
        sb4.push_back(exp);
        @(negedge clk);
        start4 = 1'b0;
        a4 = ~x; b4 = ~y; cin4 = ~ci; sub4 = ~s;
    endtask

    // Bounded wait for done, checking latency and number of busy cycles.
    task automatic waitDone4(input string tag);
        int n  = 0;
        int nb = 0;
        while (!done4 && n < 20) begin
            if (busy4) nb++;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_latency"}, n, 4);
        checkOutput({tag, "_busy_cycles"}, nb, 4);
    endtask

    // Scoreboard for the 4-word instance: every done pops one expectation.
    always @(negedge clk) begin
        if (done4) begin
            logic [20:0] e;
            checkOutput("busy_with_done4", {31'd0, busy4}, 0);
            if (sb4.size() == 0) begin
                checkOutput("unexpected_done4", {31'd0, done4}, 0);
            end else begin
                e = sb4.pop_front();
                checkOutput("sum4", {12'd0, sum4}, {12'd0, e[19:0]});
                checkOutput("cout4", {31'd0, cout4}, {31'd0, e[20]});
            end
        end
    end

    // Scoreboard for the 1-word instance.
    always @(negedge clk) begin
        if (done1) begin
            logic [5:0] e;
            checkOutput("busy_with_done1", {31'd0, busy1}, 0);
            if (sb1.size() == 0) begin
                checkOutput("unexpected_done1", {31'd0, done1}, 0);
            end else begin
                e = sb1.pop_front();
                checkOutput("sum1", {27'd0, sum1}, {27'd0, e[4:0]});
                checkOutput("cout1", {31'd0, cout1}, {31'd0, e[5]});
            end
        end
    end

    // Linear directed sequence.
    initial begin
        int n;
        logic [19:0] ra, rb;
        logic rc, rs;

        rst_n = 1'b0; clr = 1'b0;
        start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy4", {31'd0, busy4}, 0);
        checkOutput("rst_done4", {31'd0, done4}, 0);
        checkOutput("rst_sum4", {12'd0, sum4}, 0);
        checkOutput("rst_cout4", {31'd0, cout4}, 0);
        checkOutput("rst_busy1", {31'd0, busy1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] carry across all words");
        applyStimulus(20'hFFFFF, 20'h00001, 1'b0, 1'b0, {1'b1, 20'h00000});
        waitDone4("t1");
        @(negedge clk);

        $display("[TB] async reset in the middle of RUN");
        applyStimulus(20'h11111, 20'h11111, 1'b0, 1'b0, {1'b0, 20'h22222});
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy4", {31'd0, busy4}, 0);
        checkOutput("arst_done4", {31'd0, done4}, 0);
        checkOutput("arst_sum4", {12'd0, sum4}, 0);
        checkOutput("arst_cout4", {31'd0, cout4}, 0);
        sb4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("arst_idle4", {31'd0, busy4}, 0);
        applyStimulus(20'h0FFFF, 20'h00001, 1'b1, 1'b0, {1'b0, 20'h10001});
        waitDone4("post_rst");
        @(negedge clk);

        $display("[TB] clr during RUN");
        applyStimulus(20'hFFFFF, 20'hFFFFF, 1'b0, 1'b0, {1'b1, 20'hFFFFE});
        waitDone4("pre_clr");
        @(negedge clk);
        start4 = 1'b1; a4 = 20'h00001; b4 = 20'h00001; cin4 = 1'b0; sub4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("clr_busy4", {31'd0, busy4}, 0);
        checkOutput("clr_partial_sum4", {12'd0, sum4}, {12'd0, 20'hFFFE2});
        checkOutput("clr_cout_kept4", {31'd0, cout4}, 1);
        repeat (6) @(negedge clk);
        checkOutput("clr_still_idle4", {31'd0, busy4}, 0);
        clr = 1'b1; start4 = 1'b1;
        @(negedge clk);
        checkOutput("clr_start_busy4", {31'd0, busy4}, 0);
        clr = 1'b0; start4 = 1'b0;
        @(negedge clk);
        checkOutput("clr_start_idle4", {31'd0, busy4}, 0);

        $display("[TB] subtraction");
        applyStimulus(20'h12345, 20'h0ABCD, 1'b0, 1'b1, {1'b1, 20'h07778});
        waitDone4("sub1");
        @(negedge clk);
        applyStimulus(20'h00003, 20'h00005, 1'b1, 1'b1, {1'b0, 20'hFFFFE});
        waitDone4("sub2");
        @(negedge clk);

        $display("[TB] back-to-back with start held high");
        start4 = 1'b1; a4 = 20'd1; b4 = 20'd1; cin4 = 1'b0; sub4 = 1'b0;
        sb4.push_back({1'b0, 20'd2});
        @(negedge clk);
        a4 = 20'd2; b4 = 20'd2;
        sb4.push_back({1'b0, 20'd4});
        n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_first_latency", n, 4);
        @(negedge clk);
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_gap", n, 5);
        start4 = 1'b0;
        @(negedge clk);
        checkOutput("b2b_idle_after", {31'd0, busy4}, 0);

        $display("[TB] mixed operations");
        for (int i = 0; i < 4; i++) begin
            ra = 20'($urandom); rb = 20'($urandom);
            rc = 1'($urandom); rs = (i % 2 == 1);
            applyStimulus(ra, rb, rc, rs, model4(ra, rb, rc, rs));
            waitDone4("mixed");
            @(negedge clk);
        end

        $display("[TB] single-word instance");
        start1 = 1'b1; a1 = 5'h1F; b1 = 5'h1F; cin1 = 1'b1; sub1 = 1'b0;
        sb1.push_back({1'b1, 5'h1F});
        @(negedge clk);
        start1 = 1'b0;
        checkOutput("w1_busy", {31'd0, busy1}, 1);
        @(negedge clk);
        checkOutput("w1_done_at_E1", {31'd0, done1}, 1);
        @(negedge clk);
        start1 = 1'b1; a1 = 5'h03; b1 = 5'h05; cin1 = 1'b0; sub1 = 1'b1;
        sb1.push_back({1'b0, 5'h1E});
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        checkOutput("w1_sub_done", {31'd0, done1}, 1);

        repeat (3) @(negedge clk);
        checkOutput("sb4_drained", sb4.size(), 0);
        checkOutput("sb1_drained", sb1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
